// File: rtl/proc_param.sv
// Parametrised multicycle processor: eight registers (r7 = pc), registered c/n/z flags,
// PC-relative branches, compare, and a MemReady handshake for variable-latency memory.
module proc_param #(
   parameter int WIDTH    = 16,
   parameter int RESET_PC = 0
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Run,
   input  logic [WIDTH-1:0] DIN,
   input  logic             MemReady,
   output logic [WIDTH-1:0] DOUT,
   output logic [WIDTH-1:0] ADDR,
   output logic             W,
   output logic             Done,
   output logic [2:0]       Flags
);

   typedef enum logic [2:0] {
      T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
   } state_t;

   localparam logic [2:0] OP_MV    = 3'd0;
   localparam logic [2:0] OP_MVT_B = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_SUB   = 3'd3;
   localparam logic [2:0] OP_LD    = 3'd4;
   localparam logic [2:0] OP_ST    = 3'd5;
   localparam logic [2:0] OP_AND   = 3'd6;
   localparam logic [2:0] OP_CMP   = 3'd7;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q [7];
   logic [WIDTH-1:0] r_d [7];
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [15:0]      ir_q, ir_d;
   logic             w_q, w_d;
   logic [2:0]       flags_q, flags_d;

   logic [2:0]       opcode, rx, ry;
   logic             imm_sel;
   logic             is_mv, is_mvt, is_b, is_alu, is_cmp, is_ld, is_st;
   logic [WIDTH-1:0] sext_d, mvt_val, rx_val, ry_val, operand, alu_res;
   logic [WIDTH:0]   alu_sum;
   logic             alu_c, cond_true, mem_done;
   logic             wb_en;
   logic [WIDTH-1:0] wb_val;

   assign opcode  = ir_q[15:13];
   assign imm_sel = ir_q[12];
   assign rx      = ir_q[11:9];
   assign ry      = ir_q[2:0];
   assign sext_d  = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
   assign mvt_val = {ir_q[7:0], {(WIDTH-8){1'b0}}};

   assign is_mv  = (opcode == OP_MV);
   assign is_mvt = (opcode == OP_MVT_B) && imm_sel;
   assign is_b   = (opcode == OP_MVT_B) && !imm_sel;
   assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
   assign is_cmp = (opcode == OP_CMP);
   assign is_ld  = (opcode == OP_LD);
   assign is_st  = (opcode == OP_ST);

   // Loads and stores hold T5 until memory answers; everything else finishes T5 at once
   assign mem_done = !(is_ld || is_st) || MemReady;

   always_comb begin : reg_read
      rx_val = pc_q;
      ry_val = pc_q;
      for (int i = 0; i < 7; i++) begin
         if (rx == 3'(i)) rx_val = r_q[i];
         if (ry == 3'(i)) ry_val = r_q[i];
      end
   end

   assign operand = imm_sel ? sext_d : ry_val;

   always_comb begin : alu
      alu_sum = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_sum = {1'b0, a_q} + {1'b0, operand};
            alu_res = alu_sum[WIDTH-1:0];
            alu_c   = alu_sum[WIDTH];
         end
         OP_SUB, OP_CMP: begin
            alu_res = a_q - operand;
            alu_c   = (a_q >= operand);
         end
         OP_AND:  alu_res = a_q & operand;
         default: alu_res = a_q + sext_d;
      endcase
   end

   always_comb begin : branch_cond
      case (rx)
         3'd0:    cond_true = 1'b1;
         3'd1:    cond_true = flags_q[0];
         3'd2:    cond_true = !flags_q[0];
         3'd3:    cond_true = !flags_q[2];
         3'd4:    cond_true = flags_q[2];
         3'd5:    cond_true = !flags_q[1];
         3'd6:    cond_true = flags_q[1];
         default: cond_true = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= T0;
      else         state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         T0:      if (Run) state_d = T1;
         T1:      if (MemReady) state_d = T2;
         T2:      state_d = T3;
         T3:      state_d = (is_mv || is_mvt) ? T0 : T4;
         T4:      state_d = is_cmp ? T0 : T5;
         T5:      if (mem_done) state_d = T0;
         default: state_d = T0;
      endcase
   end

   always_comb begin : fsm_outputs
      case (state_q)
         T3:      Done = is_mv || is_mvt;
         T4:      Done = is_cmp;
         T5:      Done = mem_done;
         default: Done = 1'b0;
      endcase
   end

   always_comb begin : datapath
      pc_d    = pc_q;
      a_d     = a_q;
      g_d     = g_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      ir_d    = ir_q;
      w_d     = w_q;
      flags_d = flags_q;
      r_d     = r_q;
      wb_en   = 1'b0;
      wb_val  = '0;
      case (state_q)
         T0: begin
            addr_d = pc_q;
            if (Run) pc_d = pc_q + WIDTH'(1);
         end
         T2: ir_d = DIN[15:0];
         T3: begin
            if (is_mv) begin
               wb_en  = 1'b1;
               wb_val = operand;
            end else if (is_mvt) begin
               wb_en  = 1'b1;
               wb_val = mvt_val;
            end else if (is_alu || is_cmp) begin
               a_d = rx_val;
            end else if (is_b) begin
               a_d = pc_q;
            end else begin
               addr_d = ry_val;
            end
         end
         T4: begin
            if (is_alu || is_cmp || is_b) g_d = alu_res;
            if (is_alu || is_cmp) flags_d = {alu_c, alu_res[WIDTH-1], alu_res == '0};
            if (is_st) begin
               dout_d = rx_val;
               w_d    = 1'b1;
            end
         end
         T5: begin
            if (is_alu) begin
               wb_en  = 1'b1;
               wb_val = g_q;
            end
            if (is_b && cond_true) pc_d = g_q;
            if (is_ld && MemReady) begin
               wb_en  = 1'b1;
               wb_val = DIN;
            end
            if (is_st && MemReady) w_d = 1'b0;
         end
         default: ;
      endcase
      // A writeback to r7 is a jump and wins over the fetch increment
      if (wb_en) begin
         if (rx == 3'd7) pc_d = wb_val;
         for (int i = 0; i < 7; i++) begin
            if (rx == 3'(i)) r_d[i] = wb_val;
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         pc_q    <= WIDTH'(RESET_PC);
         a_q     <= '0;
         g_q     <= '0;
         addr_q  <= '0;
         dout_q  <= '0;
         ir_q    <= '0;
         w_q     <= 1'b0;
         flags_q <= '0;
         for (int i = 0; i < 7; i++) r_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         a_q     <= a_d;
         g_q     <= g_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
         ir_q    <= ir_d;
         w_q     <= w_d;
         flags_q <= flags_d;
         r_q     <= r_d;
      end
   end

   assign ADDR  = addr_q;
   assign DOUT  = dout_q;
   assign W     = w_q;
   assign Flags = flags_q;

endmodule
